// File: rtl/fence_flush_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fence_flush_sequencer_pkg
// Purpose  : Shared types and helpers for the fence / fence.i / sfence.vma
//            maintenance sequencer: sequencer state encoding, the latched
//            request flags and the stage-ordering helper.
// Revision : 1.0 - initial release
// ============================================================================
package fence_flush_sequencer_pkg;

  // Default D$ acknowledge budget, in cycles of flush_dcache_o.
  localparam int unsigned DEFAULT_ACK_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DCACHE = 3'd1,
    ICACHE = 3'd2,
    TLB    = 3'd3,
    PIPE   = 3'd4
  } fence_seq_state_e;

  // Maintenance steps still outstanding for the current sequence.
  typedef struct packed {
    logic need_d;
    logic need_i;
    logic need_t;
  } fence_req_t;

  // First outstanding step in the fixed order D$, I$, TLB; the pipeline
  // flush always closes the sequence.
  function automatic fence_seq_state_e first_stage(input fence_req_t r);
    if (r.need_d)      return DCACHE;
    else if (r.need_i) return ICACHE;
    else if (r.need_t) return TLB;
    else               return PIPE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fence_flush_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fence_flush_sequencer
// Purpose  : Turns one-cycle commit requests for fence, fence.i and
//            sfence.vma into an ordered maintenance sequence:
//            D$ flush (held until ack or timeout) -> I$ flush -> TLB flush
//            -> pipeline flush with fetch redirect to pc+4. Commit is halted
//            for the whole sequence so requests cannot overlap.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i              in   clock
//   rst_ni             in   asynchronous reset, active low
//   fence_i            in   commit fence pulse (D$ flush)
//   fence_i_i          in   commit fence.i pulse (D$ + I$ flush)
//   sfence_vma_i       in   commit sfence.vma pulse (TLB flush)
//   pc_i               in   PC of the committing instruction
//   vaddr_i            in   sfence.vma rs1 value
//   asid_i             in   sfence.vma rs2 value
//   flush_dcache_o     out  D$ flush request, level until ack/timeout
//   flush_dcache_ack_i in   D$ flush done pulse
//   flush_icache_o     out  I$ flush pulse
//   flush_tlb_o        out  TLB flush pulse
//   flush_tlb_vaddr_o  out  latched vaddr, valid with flush_tlb_o
//   flush_tlb_asid_o   out  latched asid, valid with flush_tlb_o
//   flush_pipeline_o   out  pipeline flush pulse
//   set_pc_o           out  fetch redirect, coincident with flush_pipeline_o
//   resume_pc_o        out  latched pc_i + 4, valid with set_pc_o
//   halt_commit_o      out  commit stall while a sequence is in flight
//   timeout_o          out  pulse when the D$ ack never arrived
// ============================================================================
module fence_flush_sequencer
  import fence_flush_sequencer_pkg::*;
#(
  parameter int unsigned VLEN        = 64,
  parameter int unsigned ASID_WIDTH  = 16,
  parameter int unsigned ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  fence_i,
  input  logic                  fence_i_i,
  input  logic                  sfence_vma_i,
  input  logic [VLEN-1:0]       pc_i,
  input  logic [VLEN-1:0]       vaddr_i,
  input  logic [ASID_WIDTH-1:0] asid_i,
  output logic                  flush_dcache_o,
  input  logic                  flush_dcache_ack_i,
  output logic                  flush_icache_o,
  output logic                  flush_tlb_o,
  output logic [VLEN-1:0]       flush_tlb_vaddr_o,
  output logic [ASID_WIDTH-1:0] flush_tlb_asid_o,
  output logic                  flush_pipeline_o,
  output logic                  set_pc_o,
  output logic [VLEN-1:0]       resume_pc_o,
  output logic                  halt_commit_o,
  output logic                  timeout_o
);

  localparam int unsigned        CNT_W    = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [VLEN-1:0]    PC_STEP  = VLEN'(4);

  fence_seq_state_e state_q;
  fence_seq_state_e state_d;
  fence_req_t       req_q;
  fence_req_t       req_in;
  fence_req_t       after_d;
  fence_req_t       after_i;
  logic [CNT_W-1:0] ack_cnt_q;
  logic             any_req;
  logic             ack_expired;

  assign req_in      = '{need_d: fence_i | fence_i_i,
                         need_i: fence_i_i,
                         need_t: sfence_vma_i};
  assign any_req     = fence_i | fence_i_i | sfence_vma_i;
  assign ack_expired = (ack_cnt_q == CNT_LAST);

  // Outstanding work once the D$ step (and then the I$ step) is retired.
  always_comb begin
    after_d        = req_q;
    after_d.need_d = 1'b0;
    after_i        = after_d;
    after_i.need_i = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = first_stage(req_in);
      // A timeout is treated exactly like an ack so the core never deadlocks
      // on a lost D$ response.
      DCACHE:  if (flush_dcache_ack_i || ack_expired) state_d = first_stage(after_d);
      ICACHE:  state_d = first_stage(after_i);
      TLB:     state_d = PIPE;
      PIPE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every output is registered as a decode of the next state, so each pulse
  // lines up with the cycle the sequencer sits in the matching state and no
  // input reaches an output combinationally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q           <= IDLE;
      req_q             <= '0;
      ack_cnt_q         <= '0;
      flush_dcache_o    <= 1'b0;
      flush_icache_o    <= 1'b0;
      flush_tlb_o       <= 1'b0;
      flush_tlb_vaddr_o <= '0;
      flush_tlb_asid_o  <= '0;
      flush_pipeline_o  <= 1'b0;
      set_pc_o          <= 1'b0;
      resume_pc_o       <= '0;
      halt_commit_o     <= 1'b0;
      timeout_o         <= 1'b0;
    end else begin
      state_q          <= state_d;
      flush_dcache_o   <= (state_d == DCACHE);
      flush_icache_o   <= (state_d == ICACHE);
      flush_tlb_o      <= (state_d == TLB);
      flush_pipeline_o <= (state_d == PIPE);
      set_pc_o         <= (state_d == PIPE);
      halt_commit_o    <= (state_d != IDLE);
      // An ack in the last budgeted cycle still counts as a normal ack.
      timeout_o        <= (state_q == DCACHE) && ack_expired && !flush_dcache_ack_i;

      // Counts cycles spent waiting in DCACHE; 0 on the first such cycle.
      if ((state_q == DCACHE) && (state_d == DCACHE)) begin
        ack_cnt_q <= ack_cnt_q + CNT_W'(1);
      end else begin
        ack_cnt_q <= '0;
      end

      if ((state_q == IDLE) && any_req) begin
        req_q             <= req_in;
        resume_pc_o       <= pc_i + PC_STEP;  // carry out is dropped on purpose
        flush_tlb_vaddr_o <= vaddr_i;
        flush_tlb_asid_o  <= asid_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fence_flush_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fence_flush_sequencer
// Purpose  : Directed self-checking bench for fence_flush_sequencer.
//            Output flags are packed as
//            {dcache, icache, tlb, pipeline, set_pc, halt, timeout}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fence_flush_sequencer;

  localparam int unsigned VLEN        = 64;
  localparam int unsigned ASID_WIDTH  = 16;
  localparam int unsigned ACK_TIMEOUT = 8;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic                  fence_i;
  logic                  fence_i_i;
  logic                  sfence_vma_i;
  logic [VLEN-1:0]       pc_i;
  logic [VLEN-1:0]       vaddr_i;
  logic [ASID_WIDTH-1:0] asid_i;
  logic                  flush_dcache_o;
  logic                  flush_dcache_ack_i;
  logic                  flush_icache_o;
  logic                  flush_tlb_o;
  logic [VLEN-1:0]       flush_tlb_vaddr_o;
  logic [ASID_WIDTH-1:0] flush_tlb_asid_o;
  logic                  flush_pipeline_o;
  logic                  set_pc_o;
  logic [VLEN-1:0]       resume_pc_o;
  logic                  halt_commit_o;
  logic                  timeout_o;

  logic [6:0] outs;
  assign outs = {flush_dcache_o, flush_icache_o, flush_tlb_o, flush_pipeline_o,
                 set_pc_o, halt_commit_o, timeout_o};

  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_DC   = 7'b1000010;
  localparam logic [6:0] O_IC   = 7'b0100010;
  localparam logic [6:0] O_TLB  = 7'b0010010;
  localparam logic [6:0] O_PIPE = 7'b0001110;
  localparam logic [6:0] O_PTO  = 7'b0001111;

  int n_checks = 0;
  int n_fail   = 0;

  fence_flush_sequencer #(
    .VLEN       (VLEN),
    .ASID_WIDTH (ASID_WIDTH),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .fence_i           (fence_i),
    .fence_i_i         (fence_i_i),
    .sfence_vma_i      (sfence_vma_i),
    .pc_i              (pc_i),
    .vaddr_i           (vaddr_i),
    .asid_i            (asid_i),
    .flush_dcache_o    (flush_dcache_o),
    .flush_dcache_ack_i(flush_dcache_ack_i),
    .flush_icache_o    (flush_icache_o),
    .flush_tlb_o       (flush_tlb_o),
    .flush_tlb_vaddr_o (flush_tlb_vaddr_o),
    .flush_tlb_asid_o  (flush_tlb_asid_o),
    .flush_pipeline_o  (flush_pipeline_o),
    .set_pc_o          (set_pc_o),
    .resume_pc_o       (resume_pc_o),
    .halt_commit_o     (halt_commit_o),
    .timeout_o         (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int dc_cycles;

    rst_ni             = 1'b0;
    fence_i            = 1'b0;
    fence_i_i          = 1'b0;
    sfence_vma_i       = 1'b0;
    pc_i               = '0;
    vaddr_i            = '0;
    asid_i             = '0;
    flush_dcache_ack_i = 1'b0;

    // Reset state
    tick();
    tick();
    chk("reset_outs", {57'd0, outs}, {57'd0, O_NONE});
    chk("reset_resume_pc", resume_pc_o, 64'h0);
    chk("reset_tlb_vaddr", flush_tlb_vaddr_o, 64'h0);
    chk("reset_tlb_asid", {48'd0, flush_tlb_asid_o}, 64'h0);
    rst_ni = 1'b1;
    tick();
    chk("idle_outs", {57'd0, outs}, {57'd0, O_NONE});

    // fence, ack 3 cycles after flush_dcache_o rises
    fence_i = 1'b1; pc_i = 64'h8000_0000;
    tick();                                   // c1
    fence_i = 1'b0; pc_i = '0;
    chk("f_c1", {57'd0, outs}, {57'd0, O_DC});
    tick();                                   // c2
    chk("f_c2", {57'd0, outs}, {57'd0, O_DC});
    tick();                                   // c3
    chk("f_c3", {57'd0, outs}, {57'd0, O_DC});
    tick();                                   // c4
    chk("f_c4", {57'd0, outs}, {57'd0, O_DC});
    flush_dcache_ack_i = 1'b1;
    tick();                                   // c5
    flush_dcache_ack_i = 1'b0;
    chk("f_pipe", {57'd0, outs}, {57'd0, O_PIPE});
    chk("f_resume_pc", resume_pc_o, 64'h8000_0004);
    tick();
    chk("f_idle", {57'd0, outs}, {57'd0, O_NONE});

    // fence.i, immediate ack
    fence_i_i = 1'b1; pc_i = 64'h100;
    tick();                                   // c1
    fence_i_i = 1'b0;
    chk("fi_c1", {57'd0, outs}, {57'd0, O_DC});
    flush_dcache_ack_i = 1'b1;
    tick();                                   // c2
    flush_dcache_ack_i = 1'b0;
    chk("fi_c2_icache", {57'd0, outs}, {57'd0, O_IC});
    tick();                                   // c3
    chk("fi_c3_pipe", {57'd0, outs}, {57'd0, O_PIPE});
    chk("fi_resume_pc", resume_pc_o, 64'h104);
    tick();
    chk("fi_idle", {57'd0, outs}, {57'd0, O_NONE});

    // fence.i + sfence.vma merged into one sequence
    fence_i_i = 1'b1; sfence_vma_i = 1'b1;
    pc_i = 64'h2000; vaddr_i = 64'h1000; asid_i = 16'd5;
    tick();                                   // c1
    fence_i_i = 1'b0; sfence_vma_i = 1'b0;
    vaddr_i = '0; asid_i = '0;
    chk("m_c1_dcache", {57'd0, outs}, {57'd0, O_DC});
    flush_dcache_ack_i = 1'b1;
    tick();                                   // c2
    flush_dcache_ack_i = 1'b0;
    chk("m_c2_icache", {57'd0, outs}, {57'd0, O_IC});
    tick();                                   // c3
    chk("m_c3_tlb", {57'd0, outs}, {57'd0, O_TLB});
    chk("m_tlb_vaddr", flush_tlb_vaddr_o, 64'h1000);
    chk("m_tlb_asid", {48'd0, flush_tlb_asid_o}, 64'd5);
    tick();                                   // c4
    chk("m_c4_pipe", {57'd0, outs}, {57'd0, O_PIPE});
    chk("m_resume_pc", resume_pc_o, 64'h2004);
    tick();
    chk("m_single_pipe", {57'd0, outs}, {57'd0, O_NONE});

    // fence with no ack: timeout after ACK_TIMEOUT cycles of flush_dcache_o
    fence_i = 1'b1; pc_i = 64'h3000;
    tick();                                   // c1
    fence_i = 1'b0;
    dc_cycles = 0;
    for (int i = 0; i < 20 && outs == O_DC; i++) begin
      dc_cycles++;
      tick();
    end
    chk("to_dcache_cycles", 64'(dc_cycles), 64'(ACK_TIMEOUT));
    chk("to_pulse_pipe", {57'd0, outs}, {57'd0, O_PTO});
    chk("to_resume_pc", resume_pc_o, 64'h3004);
    tick();
    chk("to_idle", {57'd0, outs}, {57'd0, O_NONE});

    // asynchronous reset in the middle of DCACHE
    fence_i = 1'b1; pc_i = 64'h5000;
    tick();                                   // c1
    fence_i = 1'b0;
    chk("rst_pre_dcache", {57'd0, outs}, {57'd0, O_DC});
    tick();                                   // c2
    rst_ni = 1'b0;
    #1;
    chk("rst_async_outs", {57'd0, outs}, {57'd0, O_NONE});
    chk("rst_async_resume", resume_pc_o, 64'h0);
    tick();
    rst_ni = 1'b1;
    tick();
    fence_i = 1'b1; pc_i = 64'h40;
    tick();                                   // c1
    fence_i = 1'b0;
    chk("post_rst_c1", {57'd0, outs}, {57'd0, O_DC});
    flush_dcache_ack_i = 1'b1;
    tick();                                   // c2
    flush_dcache_ack_i = 1'b0;
    chk("post_rst_pipe", {57'd0, outs}, {57'd0, O_PIPE});
    chk("post_rst_resume", resume_pc_o, 64'h44);
    tick();
    chk("post_rst_idle", {57'd0, outs}, {57'd0, O_NONE});

    // sfence alone with pc wrapping to 0
    sfence_vma_i = 1'b1; pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
    vaddr_i = 64'h00AB_C000; asid_i = 16'h1234;
    tick();                                   // c1
    sfence_vma_i = 1'b0; vaddr_i = '0; asid_i = '0;
    chk("s_c1_tlb", {57'd0, outs}, {57'd0, O_TLB});
    chk("s_tlb_vaddr", flush_tlb_vaddr_o, 64'h00AB_C000);
    chk("s_tlb_asid", {48'd0, flush_tlb_asid_o}, 64'h1234);
    tick();                                   // c2
    chk("s_c2_pipe", {57'd0, outs}, {57'd0, O_PIPE});
    chk("s_resume_wrap", resume_pc_o, 64'h0);
    tick();
    chk("s_idle", {57'd0, outs}, {57'd0, O_NONE});

    // spurious ack while idle
    flush_dcache_ack_i = 1'b1;
    tick();
    flush_dcache_ack_i = 1'b0;
    chk("spur_ack_outs", {57'd0, outs}, {57'd0, O_NONE});
    chk("spur_ack_resume", resume_pc_o, 64'h0);
    tick();
    chk("spur_ack_after", {57'd0, outs}, {57'd0, O_NONE});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
